// File: rtl/mystic_bram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mystic_bram_ctrl: valid/ready front end for a single-port BRAM, with    |
// | byte-strobe read-modify-write; MYSTIC_BRAM_CLEAR_EN zeroes it on reset.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mystic_bram_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    bram_we_o,
  output logic [ADDR_WIDTH-1:0]   bram_addr_o,
  output logic [DATA_WIDTH-1:0]   bram_din_o,
  input  logic [DATA_WIDTH-1:0]   bram_dout_i,
  output logic                    busy_o
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_CAP   = 3'd2,
    RMW_WAIT = 3'd3,
    RMW_WR   = 3'd4,
    RESP     = 3'd5
`ifdef MYSTIC_BRAM_CLEAR_EN
    , CLEAR  = 3'd6
`endif
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] wdata_cap, wdata_nxt;
  logic [STRB_WIDTH-1:0] wstrb_cap, wstrb_nxt;
  logic                  we_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] din_nxt;
  logic                  rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic [DATA_WIDTH-1:0] merged;
`ifdef MYSTIC_BRAM_CLEAR_EN
  logic [ADDR_WIDTH-1:0] clr_cnt, clr_cnt_nxt;
`endif

  for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_merge
    assign merged[b*8 +: 8] = wstrb_cap[b] ? wdata_cap[b*8 +: 8] : bram_dout_i[b*8 +: 8];
  end

  assign req_ready_o = (state == IDLE) && !rst_i;
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
`ifdef MYSTIC_BRAM_CLEAR_EN
      state   <= CLEAR;
      clr_cnt <= '0;
`else
      state   <= IDLE;
`endif
      wdata_cap   <= '0;
      wstrb_cap   <= '0;
      bram_we_o   <= 1'b0;
      bram_addr_o <= '0;
      bram_din_o  <= '0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
`ifdef MYSTIC_BRAM_CLEAR_EN
      clr_cnt <= clr_cnt_nxt;
`endif
      state       <= state_nxt;
      wdata_cap   <= wdata_nxt;
      wstrb_cap   <= wstrb_nxt;
      bram_we_o   <= we_nxt;
      bram_addr_o <= addr_nxt;
      bram_din_o  <= din_nxt;
      rsp_valid_o <= rsp_valid_nxt;
      rsp_rdata_o <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    wdata_nxt     = wdata_cap;
    wstrb_nxt     = wstrb_cap;
    we_nxt        = 1'b0;
    addr_nxt      = bram_addr_o;
    din_nxt       = bram_din_o;
    rsp_valid_nxt = rsp_valid_o;
    rdata_nxt     = rsp_rdata_o;
`ifdef MYSTIC_BRAM_CLEAR_EN
    clr_cnt_nxt   = clr_cnt;
`endif
    unique case (state)
      IDLE: begin
        if (req_valid_i && req_ready_o) begin
          addr_nxt  = req_addr_i;
          wdata_nxt = req_wdata_i;
          wstrb_nxt = req_wstrb_i;
          rdata_nxt = '0;
          if (!req_we_i) begin
            state_nxt = RD_WAIT;
          end else if (req_wstrb_i == '1) begin
            we_nxt    = 1'b1;
            din_nxt   = req_wdata_i;
            state_nxt = RESP;
          end else if (req_wstrb_i == '0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = RMW_WAIT;
          end
        end
      end
      RD_WAIT:  state_nxt = RD_CAP;
      RD_CAP: begin
        rdata_nxt     = bram_dout_i;
        rsp_valid_nxt = 1'b1;
        state_nxt     = RESP;
      end
      RMW_WAIT: state_nxt = RMW_WR;
      RMW_WR: begin
        we_nxt    = 1'b1;
        din_nxt   = merged;
        state_nxt = RESP;
      end
      // Writes enter RESP with rsp_valid low so the response trails the BRAM write by a cycle.
      RESP: begin
        if (!rsp_valid_o) begin
          rsp_valid_nxt = 1'b1;
        end else if (rsp_ready_i) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
`ifdef MYSTIC_BRAM_CLEAR_EN
      CLEAR: begin
        we_nxt      = 1'b1;
        addr_nxt    = clr_cnt;
        din_nxt     = '0;
        clr_cnt_nxt = clr_cnt + 1'b1;
        if (clr_cnt == '1) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mystic_bram_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mystic_bram_ctrl: self-checking bench for mystic_bram_ctrl with a     |
// | behavioural BRAM and a word-level reference memory. Revision: 1.0        |
// +--------------------------------------------------------------------------+
module tb_mystic_bram_ctrl;

  localparam int DW    = 64;
  localparam int AW    = 8;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic [SW-1:0] req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;
  logic          busy;
  logic          preload = 1'b1;

  logic [DW-1:0] mem     [0:DEPTH-1];
  logic [DW-1:0] ref_mem [0:DEPTH-1];
  int            n_pass = 0;
  int            n_total = 0;

  mystic_bram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .bram_we_o(bram_we), .bram_addr_o(bram_addr), .bram_din_o(bram_din),
    .bram_dout_i(bram_dout), .busy_o(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_word(input int i);
    if (i == 5)  return 64'h1122334455667788;
    if (i == 32) return '0;
    return {32'(i) * 32'h9E3779B9, 32'(i) ^ 32'hA5A50000};
  endfunction

  // Single-port BRAM: registered read-first output, whole-word write.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
    end else if (bram_we) begin
      mem[bram_addr] <= bram_din;
    end
    bram_dout <= mem[bram_addr];
  end

  function automatic logic [DW-1:0] apply_strobe(input logic [DW-1:0] old,
                                                 input logic [DW-1:0] wd,
                                                 input logic [SW-1:0] st);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (st[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic after_reset();
`ifdef MYSTIC_BRAM_CLEAR_EN
    int pulses, bad;
    pulses = 0;
    bad    = 0;
    for (int c = 0; c < DEPTH + 20; c++) begin
      tick();
      if (bram_we) begin
        if (bram_addr != AW'(pulses) || bram_din != '0) bad++;
        pulses++;
      end
      if (!busy) break;
    end
    chk("clear_pulses", 64'(pulses), 64'(DEPTH));
    chk("clear_addr_din", 64'(bad), 64'd0);
    chk("clear_busy_done", {63'd0, busy}, 64'd0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
    chk("idle_after_reset_busy", {63'd0, busy}, 64'd0);
    chk("idle_after_reset_ready", {63'd0, req_ready}, 64'd1);
`endif
  endtask

  task automatic txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                     input logic [SW-1:0] wstrb, input int hold, input bit keep_valid);
    int lat, wr_at, k;
    logic [DW-1:0] exp_rdata, exp_din, old;
    old     = ref_mem[addr];
    exp_din = '0;
    if (!we) begin
      lat = 2; wr_at = -1; exp_rdata = old;
    end else if (wstrb == '1) begin
      lat = 1; wr_at = 0; exp_din = wdata; exp_rdata = '0;
    end else if (wstrb == '0) begin
      lat = 1; wr_at = -1; exp_rdata = '0;
    end else begin
      lat = 3; wr_at = 2; exp_din = apply_strobe(old, wdata, wstrb); exp_rdata = '0;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    k = 0;
    while (!req_ready && k < 50) begin tick(); k++; end
    chk("req_ready_before_accept", {63'd0, req_ready}, 64'd1);
    tick();
    if (!keep_valid) begin
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_addr  = AW'($urandom);
      req_wdata = {$urandom, $urandom};
      req_wstrb = SW'($urandom);
    end
    for (int c = 0; c <= lat; c++) begin
      chk("bram_we_timing", {63'd0, bram_we}, {63'd0, (c == wr_at)});
      if (c == wr_at) begin
        chk("bram_addr_on_write", 64'(bram_addr), 64'(addr));
        chk("bram_din_on_write", bram_din, exp_din);
      end
      chk("rsp_valid_timing", {63'd0, rsp_valid}, {63'd0, (c == lat)});
      chk("req_ready_while_busy", {63'd0, req_ready}, 64'd0);
      if (c == lat) chk("rsp_rdata", rsp_rdata, exp_rdata);
      if (c < lat) tick();
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      chk("hold_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      chk("hold_rsp_rdata", rsp_rdata, exp_rdata);
      chk("hold_req_ready", {63'd0, req_ready}, 64'd0);
      chk("hold_bram_we", {63'd0, bram_we}, 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_valid_after_handshake", {63'd0, rsp_valid}, 64'd0);
    chk("busy_after_handshake", {63'd0, busy}, 64'd0);
    chk("req_ready_after_handshake", {63'd0, req_ready}, 64'd1);
    if (we) ref_mem[addr] = apply_strobe(old, wdata, wstrb);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] old30;
    int bad;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);

    // Reset state
    tick();
    preload = 1'b0;
    tick();
    chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("reset_rsp_rdata", rsp_rdata, 64'd0);
    chk("reset_bram_we", {63'd0, bram_we}, 64'd0);
    chk("reset_bram_addr", 64'(bram_addr), 64'd0);
    chk("reset_bram_din", bram_din, 64'd0);
    chk("reset_req_ready", {63'd0, req_ready}, 64'd0);
    rst = 1'b0;
    #1;
    after_reset();

    // Directed: read, full write, partial write, zero-strobe write
    txn(1'b0, 8'h05, '0, '0, 0, 1'b0);
    txn(1'b1, 8'h10, 64'hDEADBEEFCAFEF00D, 8'hFF, 1, 1'b0);
    txn(1'b0, 8'h10, '0, '0, 2, 1'b0);
    txn(1'b1, 8'h20, 64'hFFFFFFFFFFFFFFFF, 8'h0F, 0, 1'b0);
    txn(1'b0, 8'h20, '0, '0, 0, 1'b0);
    txn(1'b1, 8'h10, 64'h0123456789ABCDEF, 8'h00, 0, 1'b0);
    txn(1'b0, 8'h10, '0, '0, 0, 1'b0);

    // Back-pressure with a second request held valid throughout
    txn(1'b0, 8'h05, '0, '0, 5, 1'b1);
    txn(1'b0, 8'h05, '0, '0, 0, 1'b0);

    // Reset the cycle after a partial write is accepted
    old30 = ref_mem[8'h30];
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h30;
    req_wdata = 64'hA5A5A5A5A5A5A5A5; req_wstrb = 8'h3C;
    #1;
    chk("rmw_abort_ready", {63'd0, req_ready}, 64'd1);
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("ready_low_in_reset", {63'd0, req_ready}, 64'd0);
    tick();
    chk("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    chk("abort_bram_we", {63'd0, bram_we}, 64'd0);
    chk("abort_bram_addr", 64'(bram_addr), 64'd0);
    rst = 1'b0;
    #1;
    after_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_no_late_write", {63'd0, bram_we}, 64'd0);
      chk("abort_no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
`ifndef MYSTIC_BRAM_CLEAR_EN
    chk("abort_ref_unchanged", ref_mem[8'h30], old30);
`endif
    txn(1'b0, 8'h30, '0, '0, 0, 1'b0);

    // Randomized traffic over a small address window plus the top word
    for (int n = 0; n < 40; n++) begin
      logic [AW-1:0] a;
      logic [SW-1:0] s;
      int kind;
      a    = ($urandom_range(0, 7) == 0) ? AW'(DEPTH - 1) : AW'($urandom_range(0, 15));
      kind = $urandom_range(0, 3);
      s    = (kind == 1) ? '1 : (kind == 2) ? '0 : SW'($urandom_range(1, 254));
      txn(kind != 0, a, {$urandom, $urandom}, s, $urandom_range(0, 3), 1'b0);
    end

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_memory_image", 64'(bad), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
